// File: rtl/period_phase_pkg.sv
// Shared state, word-index and saturation constants for period_phase_reporter.
// Defining PERIOD_PHASE_STATUS_EN appends a status word to each packet.
package period_phase_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DIVIDE,
    SEND_PV,
    SEND_PI,
    SEND_PH,
    SEND_ST
  } state_t;

  localparam int WORD_PV = 0;
  localparam int WORD_PI = 1;
  localparam int WORD_PH = 2;
  localparam int WORD_ST = 3;

  // Sliced down to the quotient width wherever it is used.
  localparam logic [63:0] QUOT_SAT = '1;

`ifdef PERIOD_PHASE_STATUS_EN
  localparam state_t LAST_STATE = SEND_ST;
`else
  localparam state_t LAST_STATE = SEND_PH;
`endif

endpackage

// File: rtl/seq_restoring_divider.sv
// Restoring divider: (dividend << FRAC_BITS) / divisor, one quotient bit per cycle.
// Saturates to all ones when dividend >= divisor or divisor == 0, with the same latency.
module seq_restoring_divider
  import period_phase_pkg::*;
#(
  parameter int COUNT_WIDTH = 32,
  parameter int FRAC_BITS   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] dividend,
  input  logic [COUNT_WIDTH-1:0] divisor,
  output logic                   done,
  output logic [FRAC_BITS-1:0]   quotient,
  output logic                   zero
);

  localparam int CNT_W = $clog2(FRAC_BITS + 1);

  logic [COUNT_WIDTH:0]   rem_q;
  logic [COUNT_WIDTH-1:0] dvs_q;
  logic [FRAC_BITS-1:0]   quo_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   active_q;
  logic                   sat_q;
  logic                   zero_q;
  logic                   q_bit;

  always_comb begin
    q_bit = {rem_q, 1'b0} >= {2'b00, dvs_q};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q    <= '0;
      dvs_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      sat_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else if (start) begin
      rem_q    <= {1'b0, dividend};
      dvs_q    <= divisor;
      quo_q    <= '0;
      cnt_q    <= CNT_W'(FRAC_BITS);
      active_q <= 1'b1;
      sat_q    <= dividend >= divisor;
      zero_q   <= divisor == '0;
    end else if (active_q) begin
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
        quo_q <= (quo_q << 1) | FRAC_BITS'(q_bit);
        // Shift-and-subtract; the partial remainder stays below the divisor
        // on the non-saturating path, so the truncation loses nothing there.
        rem_q <= q_bit ? (COUNT_WIDTH+1)'({rem_q, 1'b0} - {2'b00, dvs_q})
                       : (COUNT_WIDTH+1)'({rem_q, 1'b0});
      end else begin
        active_q <= 1'b0;
      end
    end
  end

  assign done     = active_q && (cnt_q == '0);
  assign quotient = sat_q ? QUOT_SAT[FRAC_BITS-1:0] : quo_q;
  assign zero     = zero_q;

endmodule

// File: rtl/period_phase_reporter.sv
// Snapshots period/phase measurements, divides phase by period and streams one packet per
// measurement. PERIOD_PHASE_STATUS_EN adds a status word {div_zero, sat, 14'b0, drop_count}.
//   state   | meaning
//   IDLE    | waiting for a changed measurement
//   DIVIDE  | divider running on the snapshot
//   SEND_PV | streaming voltage period
//   SEND_PI | streaming current period
//   SEND_PH | streaming normalised phase
//   SEND_ST | streaming status word (status build only)
module period_phase_reporter
  import period_phase_pkg::*;
#(
  parameter int COUNT_WIDTH      = 32,
  parameter int FRAC_BITS        = 16,
  parameter int AXIS_TDATA_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [COUNT_WIDTH-1:0]      period_v,
  input  logic [COUNT_WIDTH-1:0]      period_i,
  input  logic [COUNT_WIDTH-1:0]      phase_cnt,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                        M_AXIS_tvalid,
  input  logic                        M_AXIS_tready,
  output logic                        M_AXIS_tlast,
  output logic                        busy,
  output logic                        div_zero,
  output logic [15:0]                 drop_count
);

  state_t state, state_n;

  logic [COUNT_WIDTH-1:0] prev_v, prev_i, prev_p;
  logic [COUNT_WIDTH-1:0] pend_v, pend_i, pend_p;
  logic [COUNT_WIDTH-1:0] snap_v, snap_i;
  logic [COUNT_WIDTH-1:0] op_v, op_i, op_p;
  logic                   pend_full;
  logic                   update, fire, last_fire, direct, consume, capture, start;
  logic                   div_done, div_zero_op;
  logic [FRAC_BITS-1:0]   div_quo;
  logic [1:0]             word_sel;
  logic [AXIS_TDATA_WIDTH-1:0] word;

`ifdef PERIOD_PHASE_STATUS_EN
  logic zero_this, sat_this;
`endif

  always_comb begin
    update    = {period_v, period_i, phase_cnt} != {prev_v, prev_i, prev_p};
    fire      = M_AXIS_tvalid && M_AXIS_tready;
    last_fire = (state == LAST_STATE) && fire;
    // A full slot is drained either from IDLE or straight out of the last word.
    consume   = pend_full && ((state == IDLE) || last_fire);
    direct    = (state == IDLE) && !pend_full && update;
    capture   = update && !direct;
    start     = consume || direct;
    op_v      = consume ? pend_v : period_v;
    op_i      = consume ? pend_i : period_i;
    op_p      = consume ? pend_p : phase_cnt;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start)    state_n = DIVIDE;
      DIVIDE:  if (div_done) state_n = SEND_PV;
      SEND_PV: if (fire)     state_n = SEND_PI;
      SEND_PI: if (fire)     state_n = SEND_PH;
`ifdef PERIOD_PHASE_STATUS_EN
      SEND_PH: if (fire)     state_n = SEND_ST;
      SEND_ST: if (fire)     state_n = pend_full ? DIVIDE : IDLE;
`else
      SEND_PH: if (fire)     state_n = pend_full ? DIVIDE : IDLE;
`endif
      default:               state_n = IDLE;
    endcase
  end

  always_comb begin
    case (state_n)
      SEND_PI: word_sel = 2'(WORD_PI);
      SEND_PH: word_sel = 2'(WORD_PH);
      SEND_ST: word_sel = 2'(WORD_ST);
      default: word_sel = 2'(WORD_PV);
    endcase
    case (word_sel)
      2'(WORD_PI): word = AXIS_TDATA_WIDTH'(snap_i);
      2'(WORD_PH): word = AXIS_TDATA_WIDTH'(div_quo);
`ifdef PERIOD_PHASE_STATUS_EN
      2'(WORD_ST): word = AXIS_TDATA_WIDTH'({zero_this, sat_this, 14'b0, drop_count});
`endif
      default:     word = AXIS_TDATA_WIDTH'(snap_v);
    endcase
  end

  seq_restoring_divider #(
    .COUNT_WIDTH (COUNT_WIDTH),
    .FRAC_BITS   (FRAC_BITS)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (op_p),
    .divisor  (op_v),
    .done     (div_done),
    .quotient (div_quo),
    .zero     (div_zero_op)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      prev_v        <= '0;
      prev_i        <= '0;
      prev_p        <= '0;
      pend_v        <= '0;
      pend_i        <= '0;
      pend_p        <= '0;
      pend_full     <= 1'b0;
      snap_v        <= '0;
      snap_i        <= '0;
      div_zero      <= 1'b0;
      drop_count    <= '0;
      M_AXIS_tdata  <= '0;
      M_AXIS_tvalid <= 1'b0;
      M_AXIS_tlast  <= 1'b0;
    end else begin
      state  <= state_n;
      prev_v <= period_v;
      prev_i <= period_i;
      prev_p <= phase_cnt;
      if (start) begin
        snap_v <= op_v;
        snap_i <= op_i;
      end
      if (capture) begin
        pend_v    <= period_v;
        pend_i    <= period_i;
        pend_p    <= phase_cnt;
        pend_full <= 1'b1;
        if (pend_full && !consume && drop_count != 16'hFFFF)
          drop_count <= drop_count + 16'd1;
      end else if (consume) begin
        pend_full <= 1'b0;
      end
      if (div_done && div_zero_op)
        div_zero <= 1'b1;
      M_AXIS_tvalid <= state_n inside {SEND_PV, SEND_PI, SEND_PH, SEND_ST};
      M_AXIS_tlast  <= state_n == LAST_STATE;
      // Load only on a state change so tdata holds steady through a stall.
      if (state_n != state)
        M_AXIS_tdata <= word;
    end
  end

`ifdef PERIOD_PHASE_STATUS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zero_this <= 1'b0;
      sat_this  <= 1'b0;
    end else if (start) begin
      zero_this <= op_v == '0;
      sat_this  <= op_p >= op_v;
    end
  end
`endif

  assign busy = state != IDLE;

endmodule

// File: tb/tb_period_phase_reporter.sv
// Bench for period_phase_reporter: vector table, corner sequences and randomized packets
// checked against an arithmetic model of the phase fraction.
module tb_period_phase_reporter;

  localparam int CW = 32;
  localparam int FB = 16;
  localparam int TW = 32;
`ifdef PERIOD_PHASE_STATUS_EN
  localparam int NW = 4;
`else
  localparam int NW = 3;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CW-1:0] period_v = '0, period_i = '0, phase_cnt = '0;
  logic [TW-1:0] tdata;
  logic          tvalid, tlast, busy, div_zero;
  logic          tready = 1'b0;
  logic [15:0]   drop_count;

  always #5 clk = ~clk;

  period_phase_reporter #(
    .COUNT_WIDTH      (CW),
    .FRAC_BITS        (FB),
    .AXIS_TDATA_WIDTH (TW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .period_v      (period_v),
    .period_i      (period_i),
    .phase_cnt     (phase_cnt),
    .M_AXIS_tdata  (tdata),
    .M_AXIS_tvalid (tvalid),
    .M_AXIS_tready (tready),
    .M_AXIS_tlast  (tlast),
    .busy          (busy),
    .div_zero      (div_zero),
    .drop_count    (drop_count)
  );

  typedef struct {
    logic [31:0] pv, pi, ph;
    logic [15:0] exp_q;
    logic        exp_dz;
  } vec_t;

  vec_t          tbl [7];
  int            n_pass = 0, n_total = 0;
  int            exp_drop = 0;
  logic [TW-1:0] q_data [$];
  logic          q_last [$];
  logic          stall_seen = 1'b0;
  logic [TW-1:0] stall_data;
  logic          stall_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Reference: fraction of the voltage period, saturated when >= 1 or undefined.
  function automatic logic [15:0] model_q(input logic [31:0] pv, input logic [31:0] ph);
    logic [63:0] num;
    if (pv == 0 || ph >= pv) return 16'hFFFF;
    num = {32'd0, ph} << FB;
    return 16'(num / {32'd0, pv});
  endfunction

  // Collect accepted words; a stalled word must be held unchanged.
  always @(negedge clk) begin
    if (!rst) begin
      stall_seen = 1'b0;
    end else begin
      if (stall_seen)
        chk("stall_hold", {tvalid, tlast, tdata}, {1'b1, stall_last, stall_data});
      if (tvalid && tready) begin
        q_data.push_back(tdata);
        q_last.push_back(tlast);
      end
      stall_seen = tvalid && !tready;
      stall_data = tdata;
      stall_last = tlast;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pv, input logic [31:0] pi, input logic [31:0] ph);
    period_v  = pv;
    period_i  = pi;
    phase_cnt = ph;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(0, 0, 0);
    tick();
    tick();
    rst = 1'b1;
    exp_drop = 0;
    q_data.delete();
    q_last.delete();
  endtask

  task automatic wait_valid(input string name, output int k);
    k = 0;
    while (!tvalid && k < 100) begin
      tick();
      k++;
    end
    chk({name, "_tvalid"}, tvalid, 1);
  endtask

  task automatic wait_words(input int n, input bit rnd, input string name);
    int k = 0;
    while (q_data.size() < n && k < 400) begin
      if (rnd) tready = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    chk({name, "_count"}, q_data.size(), n);
  endtask

  task automatic check_packet(input logic [31:0] pv, input logic [31:0] pi,
                              input logic [31:0] ph, input logic [15:0] exp_q,
                              input string name);
    logic [TW-1:0] exp_w [4];
    logic [TW-1:0] d;
    logic          l;
    exp_w[0] = pv;
    exp_w[1] = pi;
    exp_w[2] = TW'(exp_q);
    exp_w[3] = TW'({(pv == 0), (pv == 0 || ph >= pv), 14'b0, exp_drop[15:0]});
    if (q_data.size() < NW) begin
      q_data.delete();
      q_last.delete();
      return;
    end
    for (int i = 0; i < NW; i++) begin
      d = q_data.pop_front();
      l = q_last.pop_front();
      chk($sformatf("%s_w%0d", name, i), d, exp_w[i]);
      chk($sformatf("%s_last%0d", name, i), l, (i == NW - 1));
    end
  endtask

  task automatic run_packet(input logic [31:0] pv, input logic [31:0] pi, input logic [31:0] ph,
                            input logic [15:0] exp_q, input string name);
    int k;
    drive(pv, pi, ph);
    tick();
    wait_valid(name, k);
    chk({name, "_latency"}, k, FB + 1);
    wait_words(NW, 1'b0, name);
    check_packet(pv, pi, ph, exp_q, name);
    chk({name, "_idle"}, busy, 0);
  endtask

  initial begin
    int k;
    bit ok;
    logic [31:0] pv, pi, ph;

    tbl[0] = '{1000, 1000, 250,  16384, 0};
    tbl[1] = '{1000, 1000, 1200, 65535, 0};
    tbl[2] = '{1,    5,    0,    0,     0};
    tbl[3] = '{1000, 7,    999,  65470, 0};
    tbl[4] = '{3,    3,    1,    21845, 0};
    tbl[5] = '{0,    9,    5,    65535, 1};
    tbl[6] = '{123,  4,    0,    0,     1};

    rst = 1'b0;
    tready = 1'b1;
    repeat (3) tick();
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_div_zero", div_zero, 0);
    chk("rst_drop", drop_count, 0);
    rst = 1'b1;
    repeat (5) tick();
    chk("zero_inputs_no_update", busy, 0);

    for (int i = 0; i < 7; i++) begin
      run_packet(tbl[i].pv, tbl[i].pi, tbl[i].ph, tbl[i].exp_q, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_div_zero", i), div_zero, tbl[i].exp_dz);
    end
    do_reset();
    chk("div_zero_cleared", div_zero, 0);

    // Backpressure during SEND_PI.
    tready = 1'b0;
    drive(1000, 1000, 250);
    tick();
    wait_valid("bp", k);
    chk("bp_pv_word", tdata, 1000);
    tready = 1'b1;
    tick();
    tready = 1'b0;
    ok = 1'b1;
    repeat (50) begin
      tick();
      if (!(tvalid && tdata == 1000 && !tlast)) ok = 1'b0;
    end
    chk("bp_hold_pi", ok, 1);
    chk("bp_words_so_far", q_data.size(), 1);
    tready = 1'b1;
    wait_words(NW, 1'b0, "bp");
    check_packet(1000, 1000, 250, 16384, "bp");

    // Overrun: second update is replaced by the third.
    do_reset();
    drive(800, 11, 200);
    tick(); tick();
    drive(900, 22, 300);
    tick(); tick();
    drive(700, 33, 350);
    exp_drop = 1;
    wait_words(2 * NW, 1'b0, "ovr");
    check_packet(800, 11, 200, model_q(800, 200), "ovr_a");
    check_packet(700, 33, 350, model_q(700, 350), "ovr_c");
    chk("ovr_drop", drop_count, 1);
    repeat (30) tick();
    chk("ovr_no_extra", q_data.size(), 0);

    // Reset while a word is stalled: tvalid drops without a clock edge.
    do_reset();
    tready = 1'b0;
    drive(500, 6, 100);
    tick();
    wait_valid("rst_send", k);
    rst = 1'b0;
    drive(0, 0, 0);
    #1;
    chk("rst_send_tvalid", tvalid, 0);
    chk("rst_send_busy", busy, 0);
    tick();
    rst = 1'b1;
    tready = 1'b1;

    // Reset mid-DIVIDE with a full pending slot and a drop recorded.
    drive(600, 1, 60);
    tick(); tick();
    drive(601, 2, 61);
    tick(); tick();
    drive(602, 3, 62);
    tick(); tick();
    chk("rst_div_pre_drop", drop_count, 1);
    chk("rst_div_pre_busy", busy, 1);
    rst = 1'b0;
    drive(0, 0, 0);
    #1;
    chk("rst_div_busy", busy, 0);
    chk("rst_div_tvalid", tvalid, 0);
    chk("rst_div_drop", drop_count, 0);
    tick();
    rst = 1'b1;
    exp_drop = 0;
    q_data.delete();
    q_last.delete();
    repeat (30) tick();
    chk("rst_div_no_stale", q_data.size(), 0);
    chk("rst_div_idle", busy, 0);
    run_packet(1000, 1000, 250, 16384, "post_rst");

    // Randomized measurements with random backpressure.
    for (int n = 0; n < 20; n++) begin
      k = $urandom_range(0, 9);
      if (k == 0)      pv = 0;
      else if (k <= 2) pv = $urandom_range(1, 16);
      else             pv = $urandom;
      if (pv == 0)                       ph = $urandom;
      else if ($urandom_range(0, 3) == 0) ph = pv + $urandom_range(0, 50);
      else                               ph = $urandom % pv;
      pi = $urandom;
      if ({pv, pi, ph} == {period_v, period_i, phase_cnt}) pi = pi ^ 32'd1;
      drive(pv, pi, ph);
      tick();
      wait_words(NW, 1'b1, $sformatf("rnd%0d", n));
      check_packet(pv, pi, ph, model_q(pv, ph), $sformatf("rnd%0d", n));
      tready = 1'b1;
      tick();
    end
    chk("rnd_drop", drop_count, 0);
    chk("rnd_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
